// File: rtl/tt_uart_pkg.sv
// rtl/tt_uart_pkg.sv - shared states and pin map for the UART transmitter tile
package tt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int UIO_REQ  = 0;
  localparam int UIO_TX   = 1;
  localparam int UIO_BUSY = 2;
  localparam int UIO_DONE = 3;
  localparam int UIO_OVR  = 4;

  localparam logic [7:0] UIO_OE_MASK = 8'hFE;

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 frame shifter with registered tx; UART_TX_PARITY_EN adds an even parity bit
// done is a one-cycle strobe on the final cycle of STOP, ahead of the edge that returns to IDLE.
module uart_tx_core
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    idx_next;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign idx_next = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start) begin
          state_d = START;
          data_d  = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_next;
            tx_d  = data_q[idx_next];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/tt_um_tomamints_uart_tx.sv
// rtl/tt_um_tomamints_uart_tx.sv - Tiny Tapeout UART transmitter tile; UART_TX_PARITY_EN selects parity framing
// Owns strobe synchronisation, overrun flag, last-byte mirror and the uio pin map.
module tt_um_tomamints_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       s1_q, s2_q, s3_q;
  logic       req;
  logic       core_tx, core_busy, core_done;
  logic       done_q;
  logic       overrun_q;
  logic [7:0] byte_q;
  logic [7:0] uo_out_q;
  logic       unused_ok;

  assign req = s2_q & ~s3_q;

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .start(req),
    .data (ui_in),
    .tx   (core_tx),
    .busy (core_busy),
    .done (core_done)
  );

  // A request that arrives while a frame is in flight is dropped, only flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      byte_q    <= 8'h00;
      uo_out_q  <= 8'h00;
    end else begin
      s1_q      <= uio_in[UIO_REQ];
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      done_q    <= core_done;
      overrun_q <= overrun_q | (req & core_busy);
      if (req && !core_busy) byte_q <= ui_in;
      if (core_done) uo_out_q <= byte_q;
    end
  end

  always_comb begin
    uio_out           = 8'h00;
    uio_out[UIO_TX]   = core_tx;
    uio_out[UIO_BUSY] = core_busy;
    uio_out[UIO_DONE] = done_q;
    uio_out[UIO_OVR]  = overrun_q;
  end

  assign uo_out    = uo_out_q;
  assign uio_oe    = UIO_OE_MASK;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_tomamints_uart_tx.sv
// tb/tb_tt_um_tomamints_uart_tx.sv - randomized bench for the UART tile against a serial-frame model
module tb_tt_um_tomamints_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOTS = 11;
`else
  localparam int NSLOTS = 10;
`endif
  localparam int FRAME = NSLOTS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  tt_um_tomamints_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line level expected during sample i of a frame: start, 8 data LSB first, optional parity, stop.
  function automatic logic exp_line(input logic [7:0] b, input int i);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == NSLOTS - 1) return 1'b1;
    return ^b;
  endfunction

  // From the current negedge, wait for tx to fall; lowers the strobe as time passes.
  task automatic wait_start(input int exp_lat);
    int lat;
    lat = 0;
    while (uio_out[1] !== 1'b0 && lat < 20) begin
      @(negedge clk);
      uio_in[0] = 1'b0;
      lat++;
    end
    chk("start_latency", lat, exp_lat);
  endtask

  task automatic frame_body(input logic [7:0] b, input int ovr_at, input int chain_at,
                            input logic [7:0] chain_b, input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == abort_at) begin
        aborted = 1'b1;
        return;
      end
      chk($sformatf("tx[%0d]", i), uio_out[1], exp_line(b, i));
      chk("busy_in_frame", uio_out[2], 1'b1);
      chk("done_in_frame", uio_out[3], 1'b0);
      if (chain_at >= 0 && i >= chain_at) ui_in = chain_b;
      else ui_in = 8'($urandom);
      if (i == ovr_at || i == chain_at) uio_in[0] = 1'b1;
      if (i == ovr_at + 1 || i == chain_at + 1) uio_in[0] = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", uio_out[3], 1'b1);
    chk("busy_after", uio_out[2], 1'b0);
    chk("tx_idle", uio_out[1], 1'b1);
    chk("uo_out_byte", uo_out, b);
  endtask

  task automatic send(input logic [7:0] b, input int ovr_at);
    bit ab;
    ui_in = b;
    uio_in[0] = 1'b1;
    wait_start(3);
    frame_body(b, ovr_at, -1, 8'h00, -1, ab);
    @(negedge clk);
    chk("done_one_cycle", uio_out[3], 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", uio_out[1], 1'b1);
    chk("rst_uio_out", uio_out, 8'h02);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hFE);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit ab;
    logic [7:0] rb;
    @(negedge clk);
    do_reset();

    send(8'hA5, -1);
    chk("ovr_clear", uio_out[4], 1'b0);
    send(8'h07, -1);
    send(8'h03, -1);

    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      uio_in[7:1] = 7'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(rb, -1);
    end
    chk("ovr_after_random", uio_out[4], 1'b0);

    send(8'h3C, 10);
    chk("ovr_set", uio_out[4], 1'b1);
    repeat (20) @(negedge clk);
    chk("ovr_sticky", uio_out[4], 1'b1);
    chk("no_second_frame", uio_out[1], 1'b1);
    chk("uo_out_kept", uo_out, 8'h3C);

    do_reset();
    ui_in = 8'h01;
    uio_in[0] = 1'b1;
    wait_start(3);
    frame_body(8'h01, -1, FRAME - 2, 8'hFF, -1, ab);
    wait_start(1);
    frame_body(8'hFF, -1, -1, 8'h00, -1, ab);
    chk("b2b_ovr", uio_out[4], 1'b0);
    chk("b2b_uo_out", uo_out, 8'hFF);

    repeat (3) @(negedge clk);
    rb = 8'($urandom);
    ui_in = rb;
    uio_in[0] = 1'b1;
    wait_start(3);
    frame_body(rb, -1, -1, 8'h00, 15, ab);
    chk("abort_taken", 32'(ab), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", uio_out[1], 1'b1);
    chk("midrst_busy", uio_out[2], 1'b0);
    chk("midrst_uio_out", uio_out, 8'h02);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h5A, -1);
    chk("post_rst_ovr", uio_out[4], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
